// File: rtl/sram2axi4_lite_bridge.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sram2axi4_lite_bridge
//
// Converts single-beat SRAM-style CPU requests (instruction or data port) into
// AXI4-Lite transactions, one transaction in flight at a time. The request is
// captured on acceptance, so the core may drop ce afterwards. Every AXI VALID is
// held with a stable payload until its READY. AW and W are accepted
// independently. RRESP/BRESP errors are reported back on resp_err, which pulses
// together with the completion pulse.
//
// Ports
//   aclk, reset            clock (rising edge), asynchronous active-high reset
//   ce, we                 request strobe, direction (0 = read, 1 = write)
//   addr, wdata, wmask     request address, write data, byte enables
//   req_ready              bridge accepts a request this cycle (IDLE only)
//   rdata                  read data, held until the next read completes
//   rdata_valid            one-cycle read-complete pulse
//   write_finish           one-cycle write-complete pulse
//   resp_err               pulses with a completion whose RESP is not OKAY
//   ar_* / aw_* / wd_*     AXI4-Lite read address, write address, write data
//   rd_*                   AXI4-Lite read data channel
//   wr_*                   AXI4-Lite write response channel
//
// Every output is driven straight from a flop. Flop next-values are derived
// from the next FSM state, so each VALID/READY is already high in the first
// cycle of the state that owns it.
// -----------------------------------------------------------------------------
module sram2axi4_lite_bridge #(
  parameter int         ADDR_WIDTH = 32,
  parameter int         DATA_WIDTH = 32,
  parameter logic [2:0] PROT       = 3'b000
) (
  input  logic                    aclk,
  input  logic                    reset,
  // CPU request side
  input  logic                    ce,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wmask,
  output logic                    req_ready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rdata_valid,
  output logic                    write_finish,
  output logic                    resp_err,
  // AXI4-Lite read address channel
  output logic                    ar_valid,
  input  logic                    ar_ready,
  output logic [ADDR_WIDTH-1:0]   ar_addr,
  output logic [2:0]              ar_prot,
  // AXI4-Lite write address channel
  output logic                    aw_valid,
  input  logic                    aw_ready,
  output logic [ADDR_WIDTH-1:0]   aw_addr,
  output logic [2:0]              aw_prot,
  // AXI4-Lite write data channel
  output logic                    wd_valid,
  input  logic                    wd_ready,
  output logic [DATA_WIDTH-1:0]   wd_data,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  // AXI4-Lite read data channel
  input  logic                    rd_valid,
  output logic                    rd_ready,
  input  logic [DATA_WIDTH-1:0]   rd_data,
  input  logic [1:0]              rd_resp,
  // AXI4-Lite write response channel
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [1:0]              wr_bresp
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_RESP = 3'd4
  } state_t;

  // Any AXI response other than OKAY (2'b00) is reported as an error.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp != 2'b00);
  endfunction

  state_t state_r;
  state_t state_nxt_s;

  // Captured request. The direction is held by the FSM state itself.
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic [STRB_WIDTH-1:0] wmask_r;

  // Per-channel write handshake flags.
  logic aw_done_r;
  logic w_done_r;
  logic aw_done_nxt_s;
  logic w_done_nxt_s;

  // Output flops and their next values.
  logic                  req_ready_r,    req_ready_nxt_s;
  logic                  ar_valid_r,     ar_valid_nxt_s;
  logic                  aw_valid_r,     aw_valid_nxt_s;
  logic                  wd_valid_r,     wd_valid_nxt_s;
  logic                  rd_ready_r,     rd_ready_nxt_s;
  logic                  wr_ready_r,     wr_ready_nxt_s;
  logic                  rdata_valid_r,  rdata_valid_nxt_s;
  logic                  write_finish_r, write_finish_nxt_s;
  logic                  resp_err_r,     resp_err_nxt_s;
  logic [DATA_WIDTH-1:0] rdata_r,        rdata_nxt_s;

  // Handshakes and request acceptance.
  logic accept_s;
  logic ar_hs_s;
  logic aw_hs_s;
  logic w_hs_s;
  logic rd_hs_s;
  logic b_hs_s;

  assign accept_s = ce & req_ready_r;
  assign ar_hs_s  = ar_valid_r & ar_ready;
  assign aw_hs_s  = aw_valid_r & aw_ready;
  assign w_hs_s   = wd_valid_r & wd_ready;
  assign rd_hs_s  = rd_ready_r & rd_valid;
  assign b_hs_s   = wr_ready_r & wr_valid;

  // FSM state register
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Write handshake flags; the current cycle's handshake counts immediately
  // so AW and W completing together can leave WR_REQ on that same edge.
  always_comb begin
    if (state_r == ST_WR_REQ) begin
      aw_done_nxt_s = aw_done_r | aw_hs_s;
      w_done_nxt_s  = w_done_r | w_hs_s;
    end else begin
      aw_done_nxt_s = 1'b0;
      w_done_nxt_s  = 1'b0;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = we ? ST_WR_REQ : ST_RD_ADDR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RD_ADDR: begin
        if (ar_hs_s) begin
          state_nxt_s = ST_RD_DATA;
        end else begin
          state_nxt_s = ST_RD_ADDR;
        end
      end
      ST_RD_DATA: begin
        if (rd_hs_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RD_DATA;
        end
      end
      ST_WR_REQ: begin
        if (aw_done_nxt_s && w_done_nxt_s) begin
          state_nxt_s = ST_WR_RESP;
        end else begin
          state_nxt_s = ST_WR_REQ;
        end
      end
      ST_WR_RESP: begin
        if (b_hs_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WR_RESP;
        end
      end
      default: begin
        // Unreachable encoding: recover to a safe idle state.
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM output logic: next values for every registered output
  always_comb begin
    req_ready_nxt_s = (state_nxt_s == ST_IDLE);
    ar_valid_nxt_s  = (state_nxt_s == ST_RD_ADDR);
    rd_ready_nxt_s  = (state_nxt_s == ST_RD_DATA);
    wr_ready_nxt_s  = (state_nxt_s == ST_WR_RESP);
    // A write channel's VALID stays low once its handshake has happened.
    aw_valid_nxt_s  = (state_nxt_s == ST_WR_REQ) & ~aw_done_nxt_s;
    wd_valid_nxt_s  = (state_nxt_s == ST_WR_REQ) & ~w_done_nxt_s;

    rdata_nxt_s        = rdata_r;
    rdata_valid_nxt_s  = 1'b0;
    write_finish_nxt_s = 1'b0;
    resp_err_nxt_s     = 1'b0;
    case (state_r)
      ST_RD_DATA: begin
        if (rd_hs_s) begin
          // Data is captured even on an error response.
          rdata_nxt_s       = rd_data;
          rdata_valid_nxt_s = 1'b1;
          resp_err_nxt_s    = resp_is_err(rd_resp);
        end else begin
          rdata_nxt_s       = rdata_r;
        end
      end
      ST_WR_RESP: begin
        if (b_hs_s) begin
          write_finish_nxt_s = 1'b1;
          resp_err_nxt_s     = resp_is_err(wr_bresp);
        end else begin
          write_finish_nxt_s = 1'b0;
        end
      end
      default: begin
        rdata_nxt_s = rdata_r;
      end
    endcase
  end

  // Request capture on acceptance
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      addr_r  <= {ADDR_WIDTH{1'b0}};
      wdata_r <= {DATA_WIDTH{1'b0}};
      wmask_r <= {STRB_WIDTH{1'b0}};
    end else if (accept_s) begin
      addr_r  <= addr;
      wdata_r <= wdata;
      wmask_r <= wmask;
    end else begin
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
      wmask_r <= wmask_r;
    end
  end

  // Write handshake flag registers
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
    end else begin
      aw_done_r <= aw_done_nxt_s;
      w_done_r  <= w_done_nxt_s;
    end
  end

  // Registered AXI handshake signals and completion outputs
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      req_ready_r    <= 1'b0;
      ar_valid_r     <= 1'b0;
      aw_valid_r     <= 1'b0;
      wd_valid_r     <= 1'b0;
      rd_ready_r     <= 1'b0;
      wr_ready_r     <= 1'b0;
      rdata_valid_r  <= 1'b0;
      write_finish_r <= 1'b0;
      resp_err_r     <= 1'b0;
      rdata_r        <= {DATA_WIDTH{1'b0}};
    end else begin
      req_ready_r    <= req_ready_nxt_s;
      ar_valid_r     <= ar_valid_nxt_s;
      aw_valid_r     <= aw_valid_nxt_s;
      wd_valid_r     <= wd_valid_nxt_s;
      rd_ready_r     <= rd_ready_nxt_s;
      wr_ready_r     <= wr_ready_nxt_s;
      rdata_valid_r  <= rdata_valid_nxt_s;
      write_finish_r <= write_finish_nxt_s;
      resp_err_r     <= resp_err_nxt_s;
      rdata_r        <= rdata_nxt_s;
    end
  end

  assign req_ready    = req_ready_r;
  assign rdata        = rdata_r;
  assign rdata_valid  = rdata_valid_r;
  assign write_finish = write_finish_r;
  assign resp_err     = resp_err_r;

  assign ar_valid = ar_valid_r;
  assign ar_addr  = addr_r;
  assign ar_prot  = PROT;

  assign aw_valid = aw_valid_r;
  assign aw_addr  = addr_r;
  assign aw_prot  = PROT;

  assign wd_valid = wd_valid_r;
  assign wd_data  = wdata_r;
  assign wstrb    = wmask_r;

  assign rd_ready = rd_ready_r;
  assign wr_ready = wr_ready_r;

endmodule

// File: tb/tb_sram2axi4_lite_bridge.sv
`timescale 1ns/1ps
// Scoreboard bench for sram2axi4_lite_bridge: stimulus pushes expected
// completions, a monitor pops and compares on each completion pulse and checks
// AXI channel payloads/stability. A configurable slave model answers the bus.
module tb_sram2axi4_lite_bridge;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          aclk = 1'b0;
  logic          reset = 1'b1;
  logic          ce = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [SW-1:0] wmask = '0;
  logic          req_ready;
  logic [DW-1:0] rdata;
  logic          rdata_valid, write_finish, resp_err;
  logic          ar_valid, ar_ready = 1'b0;
  logic [AW-1:0] ar_addr;
  logic [2:0]    ar_prot;
  logic          aw_valid, aw_ready = 1'b0;
  logic [AW-1:0] aw_addr;
  logic [2:0]    aw_prot;
  logic          wd_valid, wd_ready = 1'b0;
  logic [DW-1:0] wd_data;
  logic [SW-1:0] wstrb;
  logic          rd_valid = 1'b0, rd_ready;
  logic [DW-1:0] rd_data = '0;
  logic [1:0]    rd_resp = 2'b00;
  logic          wr_valid = 1'b0, wr_ready;
  logic [1:0]    wr_bresp = 2'b00;

  sram2axi4_lite_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PROT(3'b000)) dut (
    .aclk(aclk), .reset(reset), .ce(ce), .we(we), .addr(addr), .wdata(wdata),
    .wmask(wmask), .req_ready(req_ready), .rdata(rdata), .rdata_valid(rdata_valid),
    .write_finish(write_finish), .resp_err(resp_err),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_prot(ar_prot),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_prot(aw_prot),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wstrb(wstrb),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_resp(rd_resp),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_bresp(wr_bresp)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  typedef struct {
    logic          is_wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wmask;
    logic [DW-1:0] rdata;
    logic          err;
    int            exp_cyc;   // -1 when the completion cycle is not checked
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;

  // slave configuration (wait cycles before READY/VALID, response values)
  int         ar_wait = 0, aw_wait = 0, w_wait = 0, r_wait = 0, b_wait = 0;
  logic [DW-1:0] r_data_cfg = '0;
  logic [1:0]    r_resp_cfg = 2'b00, b_resp_cfg = 2'b00;

  // monitor state
  int            ar_hs = 0, aw_hs = 0, w_hs = 0;
  logic [DW-1:0] last_rd = '0;
  logic          p_ar_v = 1'b0, p_ar_r = 1'b0, p_aw_v = 1'b0, p_aw_r = 1'b0;
  logic          p_w_v = 1'b0, p_w_r = 1'b0;
  logic [AW-1:0] p_ar_addr = '0, p_aw_addr = '0;
  logic [DW-1:0] p_wd_data = '0;
  logic [SW-1:0] p_wstrb = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge aclk);
      if (reset) begin
        ar_hs = 0; aw_hs = 0; w_hs = 0; last_rd = '0;
        p_ar_v = 1'b0; p_aw_v = 1'b0; p_w_v = 1'b0;
      end else begin
        if (p_ar_v && !p_ar_r) begin
          chk("ar_valid_held", ar_valid, 1);
          chk("ar_addr_stable", ar_addr, p_ar_addr);
        end
        if (p_aw_v && !p_aw_r) begin
          chk("aw_valid_held", aw_valid, 1);
          chk("aw_addr_stable", aw_addr, p_aw_addr);
        end
        if (p_w_v && !p_w_r) begin
          chk("wd_valid_held", wd_valid, 1);
          chk("wd_payload_stable", {wd_data, wstrb}, {p_wd_data, p_wstrb});
        end
        if (ar_valid && ar_ready) begin
          ar_hs++;
          chk("ar_inflight", exp_q.size(), 1);
          if (exp_q.size() > 0) begin
            chk("ar_addr", ar_addr, exp_q[0].addr);
            chk("ar_prot", ar_prot, 3'b000);
          end
        end
        if (aw_valid && aw_ready) begin
          aw_hs++;
          chk("aw_inflight", exp_q.size(), 1);
          if (exp_q.size() > 0) begin
            chk("aw_addr", aw_addr, exp_q[0].addr);
            chk("aw_prot", aw_prot, 3'b000);
          end
        end
        if (wd_valid && wd_ready) begin
          w_hs++;
          chk("w_inflight", exp_q.size(), 1);
          if (exp_q.size() > 0) begin
            chk("wd_data", wd_data, exp_q[0].wdata);
            chk("wstrb", wstrb, exp_q[0].wmask);
          end
        end
        if (rdata_valid) begin
          chk("rd_pending", exp_q.size(), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rd_kind_is_write", e.is_wr, 0);
            chk("rdata", rdata, e.rdata);
            chk("rd_resp_err", resp_err, e.err);
            chk("rd_req_ready", req_ready, 1);
            chk("ar_hs_count", ar_hs, 1);
            if (e.exp_cyc >= 0) chk("rd_cycle", cyc, e.exp_cyc);
            last_rd = e.rdata;
          end
          ar_hs = 0;
        end
        if (write_finish) begin
          chk("wr_pending", exp_q.size(), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("wr_kind_is_write", e.is_wr, 1);
            chk("wr_resp_err", resp_err, e.err);
            chk("wr_req_ready", req_ready, 1);
            chk("aw_hs_count", aw_hs, 1);
            chk("w_hs_count", w_hs, 1);
            chk("rdata_held", rdata, last_rd);
            if (e.exp_cyc >= 0) chk("wr_cycle", cyc, e.exp_cyc);
          end
          aw_hs = 0; w_hs = 0;
        end
        if (!rdata_valid && !write_finish) chk("resp_err_idle", resp_err, 0);
        p_ar_v = ar_valid; p_ar_r = ar_ready; p_ar_addr = ar_addr;
        p_aw_v = aw_valid; p_aw_r = aw_ready; p_aw_addr = aw_addr;
        p_w_v = wd_valid; p_w_r = wd_ready; p_wd_data = wd_data; p_wstrb = wstrb;
      end
    end
  endtask

  // AXI slave model
  initial begin
    int ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt;
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
    forever begin
      @(posedge aclk);
      #1;
      if (reset) begin
        ar_ready = 1'b0; aw_ready = 1'b0; wd_ready = 1'b0; rd_valid = 1'b0; wr_valid = 1'b0;
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
      end else begin
        if (ar_valid) begin
          if (ar_cnt >= ar_wait) ar_ready = 1'b1; else begin ar_ready = 1'b0; ar_cnt++; end
        end else begin ar_ready = 1'b0; ar_cnt = 0; end
        if (aw_valid) begin
          if (aw_cnt >= aw_wait) aw_ready = 1'b1; else begin aw_ready = 1'b0; aw_cnt++; end
        end else begin aw_ready = 1'b0; aw_cnt = 0; end
        if (wd_valid) begin
          if (w_cnt >= w_wait) wd_ready = 1'b1; else begin wd_ready = 1'b0; w_cnt++; end
        end else begin wd_ready = 1'b0; w_cnt = 0; end
        if (rd_ready) begin
          if (r_cnt >= r_wait) begin
            rd_valid = 1'b1; rd_data = r_data_cfg; rd_resp = r_resp_cfg;
          end else begin rd_valid = 1'b0; r_cnt++; end
        end else begin rd_valid = 1'b0; r_cnt = 0; end
        if (wr_ready) begin
          if (b_cnt >= b_wait) begin
            wr_valid = 1'b1; wr_bresp = b_resp_cfg;
          end else begin wr_valid = 1'b0; b_cnt++; end
        end else begin wr_valid = 1'b0; b_cnt = 0; end
      end
    end
  end

  // Hold ce until accepted, then push the expected completion.
  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [SW-1:0] m, input logic [DW-1:0] rd_d,
                       input logic [1:0] rsp, input bit tcyc);
    exp_t e;
    logic rdy;
    bit   ok;
    if (w) b_resp_cfg = rsp;
    else begin r_data_cfg = rd_d; r_resp_cfg = rsp; end
    we = w; addr = a; wdata = d; wmask = m; ce = 1'b1; ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      rdy = req_ready;
      tick();
      if (rdy) ok = 1'b1;
    end
    ce = 1'b0;
    chk("accept_timeout", ok, 1);
    if (ok) begin
      e.is_wr = w; e.addr = a; e.wdata = d; e.wmask = m; e.rdata = rd_d;
      e.err = (rsp != 2'b00);
      e.exp_cyc = tcyc ? cyc + 2 : -1;
      exp_q.push_back(e);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) tick();
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic check_reset_outs(input string name);
    chk(name, {ar_valid, aw_valid, wd_valid, rd_ready, wr_ready, req_ready,
               rdata_valid, write_finish, resp_err}, 9'd0);
    chk({name, "_rdata"}, rdata, 32'h0);
  endtask

  initial begin
    bit ok;
    fork monitor(); join_none

    // reset state
    repeat (3) @(posedge aclk);
    #1;
    check_reset_outs("reset_outs");
    reset = 1'b0;
    tick();
    chk("req_ready_after_reset", req_ready, 1);

    // zero-wait read with cycle-accurate completion
    issue(1'b0, 32'h0000_1000, 32'h0, 4'b0000, 32'hDEAD_BEEF, 2'b00, 1'b1);
    drain();

    // write: AW accepted 3 cycles before W
    aw_wait = 0; w_wait = 3;
    issue(1'b1, 32'h0000_2004, 32'hA5A5_A5A5, 4'b0011, 32'h0, 2'b00, 1'b0);
    tick();
    chk("aw_valid_dropped", aw_valid, 0);
    chk("wd_valid_still_high", wd_valid, 1);
    drain();
    w_wait = 0;

    // AR stalled 5 cycles; ce pulses during the stall must be ignored
    ar_wait = 5;
    issue(1'b0, 32'h0000_1008, 32'h0, 4'b0000, 32'h5555_AAAA, 2'b00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      ce = (i % 2 == 0); we = 1'b1; addr = 32'h0000_9990 + i; wdata = 32'hFFFF_0000 + i;
      tick();
      chk("req_ready_stall", req_ready, 0);
      chk("ar_valid_stall", ar_valid, 1);
    end
    ce = 1'b0;
    drain();
    ar_wait = 0;

    // error responses
    issue(1'b0, 32'h0000_1010, 32'h0, 4'b0000, 32'h0BAD_F00D, 2'b10, 1'b1);
    drain();
    issue(1'b1, 32'h0000_2010, 32'h1234_5678, 4'b1100, 32'h0, 2'b11, 1'b1);
    drain();

    // back-to-back read/write/read, ce raised while busy
    issue(1'b0, 32'h0000_4000, 32'h0, 4'b0000, 32'h1111_1111, 2'b00, 1'b1);
    issue(1'b1, 32'h0000_4004, 32'h2222_2222, 4'b1111, 32'h0, 2'b00, 1'b1);
    issue(1'b0, 32'h0000_4008, 32'h0, 4'b0000, 32'h3333_3333, 2'b00, 1'b1);
    drain();

    // reset while in WR_RESP
    b_wait = 1000;
    issue(1'b1, 32'h0000_5000, 32'hCAFE_CAFE, 4'b1111, 32'h0, 2'b00, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (wr_ready) ok = 1'b1;
    end
    chk("reached_wr_resp", ok, 1);
    repeat (2) tick();
    #2;
    reset = 1'b1;
    #1;
    check_reset_outs("mid_reset_outs");
    exp_q.delete();
    tick();
    reset = 1'b0;
    b_wait = 0;
    tick();
    chk("req_ready_after_mid_reset", req_ready, 1);
    issue(1'b0, 32'h0000_3000, 32'h0, 4'b0000, 32'h1234_ABCD, 2'b00, 1'b1);
    drain();

    repeat (5) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sram2axi4_lite_bridge.md
# sram2axi4_lite_bridge

Registered, fully handshaked successor to the combinational SRAM-to-AXI4-Lite shim: converts single-beat SRAM-style CPU requests (instruction or data port) into AXI4-Lite transactions. Captures each request, holds every AXI VALID until its READY, handles independent AW/W acceptance, and reports RRESP/BRESP errors back to the core. Sits between a CPU memory port and the AXI4-Lite interconnect; one transaction in flight at a time.

## Interface
- ADDR_WIDTH, 32, address width (sram and AXI)
- DATA_WIDTH, 32, data width; strobe width DATA_WIDTH/8
- PROT, 3'b000, constant driven on ar_prot/aw_prot
- aclk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- ce  in  1  request strobe
- we  in  1  0 = read, 1 = write
- addr  in  ADDR_WIDTH  request address, passed unmodified
- wdata  in  DATA_WIDTH  write data
- wmask  in  DATA_WIDTH/8  byte enables
- req_ready  out  1  bridge can accept a request this cycle
- rdata  out  DATA_WIDTH  read data, registered, held until next read completes
- rdata_valid  out  1  one-cycle read-complete pulse
- write_finish  out  1  one-cycle write-complete pulse
- resp_err  out  1  pulses with rdata_valid/write_finish when RESP != OKAY
- ar_valid/ar_ready/ar_addr/ar_prot  out/in/out/out  1/1/ADDR_WIDTH/3  read address channel
- aw_valid/aw_ready/aw_addr/aw_prot  out/in/out/out  1/1/ADDR_WIDTH/3  write address channel
- wd_valid/wd_ready/wd_data/wstrb  out/in/out/out  1/1/DATA_WIDTH/DATA_WIDTH/8  write data channel
- rd_valid/rd_ready/rd_data/rd_resp  in/out/in/in  1/1/DATA_WIDTH/2  read data channel
- wr_valid/wr_ready/wr_bresp  in/out/in  1/1/2  write response channel

## Operation
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- req_ready = 1 only in IDLE. Acceptance = ce & req_ready: addr, wdata, wmask, we captured into registers; ce may drop afterwards. ce outside IDLE ignored.
- IDLE -> RD_ADDR (we=0) or WR_REQ (we=1) on acceptance.
- RD_ADDR: ar_valid=1, ar_addr from capture register; on ar_ready -> RD_DATA.
- RD_DATA: rd_ready=1; on rd_valid: rdata <= rd_data (captured even on error), rdata_valid and resp_err=(rd_resp!=0) pulse next cycle, -> IDLE.
- WR_REQ: aw_valid and wd_valid both asserted on entry; aw_done/w_done flags set on each handshake; a channel's VALID drops the cycle after its handshake and stays low. Both handshakes in the same cycle allowed. When both done (including the handshaking cycle) -> WR_RESP.
- WR_RESP: wr_ready=1; on wr_valid: write_finish and resp_err=(wr_bresp!=0) pulse next cycle, -> IDLE.
- Outputs driven only from registers (ar/aw/wd valid, addr, data, strobe, pulses); AXI payloads stable while VALID high.
- rd_ready low outside RD_DATA; wr_ready low outside WR_RESP.

## Timing
- Reset (async assert): state IDLE, all VALID/READY outputs 0, rdata 0, rdata_valid 0, write_finish 0, resp_err 0, done flags 0, capture regs 0; req_ready 1 after reset released. Reset mid-transaction abandons it with no completion pulse.
- Read, zero-wait slave: accept edge 0; ar_valid high cycle 1; rd_ready high cycle 2; rdata_valid high cycle 3, same cycle req_ready=1. Back-to-back throughput: one read per 3 cycles.
- Write, zero-wait slave: aw_valid/wd_valid high cycle 1; wr_ready cycle 2; write_finish cycle 3.
- Completion pulse cycle coincides with IDLE; a ce in that cycle is accepted.
- Slave stalls extend states arbitrarily; no timeout.

## Test plan
- Read 0x1000, ar_ready=1, rd_valid with 0xDEADBEEF resp 0 one cycle later -> rdata_valid at cycle 3, rdata=0xDEADBEEF, resp_err=0.
- Write 0x2004 wdata 0xA5A5A5A5 wmask 4'b0011, aw_ready 3 cycles before wd_ready -> aw_valid drops after its handshake, wd_valid held until wd_ready, wstrb=0011, exactly one write_finish after wr_valid.
- ar_ready held low 5 cycles -> ar_valid and ar_addr stable throughout, ce pulses during stall ignored, req_ready=0.
- Read with rd_resp=2'b10, then write with wr_bresp=2'b11 -> resp_err pulses with each completion, rdata updated.
- Back-to-back read/write/read with ce asserted in each completion cycle -> each accepted on that cycle, no lost or duplicate pulse.
- Reset asserted during WR_RESP -> all outputs zero immediately, no write_finish, next read completes normally.
